// File: rtl/alu_result_skid_buffer_pkg.sv
// Shared definitions for the ALU result path: op codes and the result entry record.
// The memory stage uses the same encoding.
package alu_result_skid_buffer_pkg;

   localparam logic [2:0] OP_AND = 3'd0;
   localparam logic [2:0] OP_OR  = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_SUB = 3'd6;
   localparam logic [2:0] OP_SLT = 3'd7;

   localparam int ALU_W = 8;

   typedef struct packed {
      logic [ALU_W-1:0] z;
      logic             zero;
      logic [2:0]       op;
   } alu_entry_t;

   localparam int ALU_ENTRY_W = $bits(alu_entry_t);

   // Packed entry width for an arbitrary data width: z + zero flag + 3-bit op.
   function automatic int entry_w(input int width);
      return width + 4;
   endfunction

endpackage

// File: rtl/alu_result_entry_reg.sv
// One skid-buffer entry: load-enabled register, cleared by synchronous reset.
module alu_result_entry_reg #(
   parameter int W = 12
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         ld,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset)   q <= '0;
      else if (ld) q <= d;
   end

endmodule

// File: rtl/alu_result_skid_buffer.sv
// Two-entry registered skid buffer behind yAlu: head drives out_*, skid absorbs one
// result of back-pressure. Also flags inconsistent zero flags and counts transfers.
module alu_result_skid_buffer
   import alu_result_skid_buffer_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_z,
   input  logic             in_zero,
   input  logic [2:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_z,
   output logic             out_zero,
   output logic [2:0]       out_op,
   output logic [1:0]       count,
   output logic             zero_err,
   output logic [CNT_W-1:0] xfer_count
);

   localparam int EW = entry_w(WIDTH);

   logic          h_vld, s_vld, h_vld_n, s_vld_n;
   logic          acc, pop, h_ld, s_ld;
   logic [EW-1:0] in_e, h_d, h_q, s_q;

   assign acc  = in_valid & in_ready;
   assign pop  = h_vld & out_ready;
   assign in_e = {in_z, in_zero, in_op};

   // With the skid full in_ready is low, so the only move is skid -> head on pop.
   always_comb begin
      h_d     = in_e;
      h_ld    = 1'b0;
      s_ld    = 1'b0;
      h_vld_n = h_vld;
      s_vld_n = s_vld;
      if (s_vld) begin
         h_d     = s_q;
         h_ld    = pop;
         s_vld_n = ~pop;
      end else begin
         h_ld    = acc & (~h_vld | pop);
         s_ld    = acc & h_vld & ~pop;
         h_vld_n = acc | (h_vld & ~pop);
         s_vld_n = s_ld;
      end
   end

   alu_result_entry_reg #(.W(EW)) u_head (
      .clk(clk), .reset(reset), .ld(h_ld), .d(h_d), .q(h_q)
   );

   alu_result_entry_reg #(.W(EW)) u_skid (
      .clk(clk), .reset(reset), .ld(s_ld), .d(in_e), .q(s_q)
   );

   assign out_valid                 = h_vld;
   assign {out_z, out_zero, out_op} = h_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         h_vld      <= 1'b0;
         s_vld      <= 1'b0;
         in_ready   <= 1'b1;
         count      <= 2'd0;
         zero_err   <= 1'b0;
         xfer_count <= '0;
      end else begin
         h_vld      <= h_vld_n;
         s_vld      <= s_vld_n;
         in_ready   <= ~s_vld_n;
         count      <= {1'b0, h_vld_n} + {1'b0, s_vld_n};
         xfer_count <= xfer_count + CNT_W'(pop);
         if (acc && (in_zero != (in_z == {WIDTH{1'b0}})))
            zero_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_alu_result_skid_buffer.sv
// Bench for alu_result_skid_buffer: hand-written vector table, then random traffic
// against a queue-based reference model.
module tb_alu_result_skid_buffer;
   import alu_result_skid_buffer_pkg::*;

   localparam int WIDTH = 8;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset, in_valid, in_ready, in_zero, out_valid, out_ready, out_zero, zero_err;
   logic [WIDTH-1:0] in_z, out_z;
   logic [2:0]       in_op, out_op;
   logic [1:0]       count;
   logic [CNT_W-1:0] xfer_count;

   always #5 clk = ~clk;

   alu_result_skid_buffer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_z(in_z), .in_zero(in_zero), .in_op(in_op),
      .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
      .out_zero(out_zero), .out_op(out_op), .count(count),
      .zero_err(zero_err), .xfer_count(xfer_count)
   );

   int checks = 0;
   int errors = 0;

   // reference model state
   alu_entry_t m_q[$];
   bit         m_zerr;
   int         m_xfer;
   int         m_pops;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance one clock: model computes its next state from the rules, then all outputs are compared.
   task automatic tick();
      bit         m_acc, m_pop;
      alu_entry_t e;
      m_acc = in_valid && (m_q.size() < 2);
      m_pop = out_ready && (m_q.size() > 0);
      e.z = in_z; e.zero = in_zero; e.op = in_op;
      @(posedge clk);
      #1;
      if (reset) begin
         m_q.delete(); m_zerr = 0; m_xfer = 0;
      end else begin
         if (m_pop) begin
            void'(m_q.pop_front());
            m_xfer = (m_xfer + 1) % (1 << CNT_W);
            m_pops++;
         end
         if (m_acc) begin
            m_q.push_back(e);
            if (in_zero != (in_z == 0)) m_zerr = 1;
         end
      end
      chk("out_valid", int'(out_valid), int'(m_q.size() > 0));
      chk("count", int'(count), m_q.size());
      chk("in_ready", int'(in_ready), int'(m_q.size() < 2));
      chk("zero_err", int'(zero_err), int'(m_zerr));
      chk("xfer_count", int'(xfer_count), m_xfer);
      if (m_q.size() > 0) begin
         chk("out_z", int'(out_z), int'(m_q[0].z));
         chk("out_zero", int'(out_zero), int'(m_q[0].zero));
         chk("out_op", int'(out_op), int'(m_q[0].op));
      end else if (reset) begin
         chk("out_z_rst", int'({out_z, out_zero, out_op}), 0);
      end
   endtask

   typedef struct {
      bit       rst, iv, zf, ordy;
      bit [7:0] z;
      bit [2:0] op;
      bit       e_ov, e_ir, e_ze;
      bit [1:0] e_cnt;
      bit [7:0] e_z;
      int       e_xf;
   } vec_t;

   vec_t tbl[15];

   function automatic vec_t mk(bit rst, bit iv, bit [7:0] z, bit zf, bit [2:0] op, bit ordy,
                               bit e_ov, bit [7:0] e_z, bit [1:0] e_cnt, bit e_ir, int e_xf, bit e_ze);
      vec_t v;
      v.rst = rst; v.iv = iv; v.z = z; v.zf = zf; v.op = op; v.ordy = ordy;
      v.e_ov = e_ov; v.e_z = e_z; v.e_cnt = e_cnt; v.e_ir = e_ir; v.e_xf = e_xf; v.e_ze = e_ze;
      return v;
   endfunction

   initial begin
      int start_x, a, b, budget;
      bit [7:0] d;
      reset = 1'b1; in_valid = 1'b0; in_z = '0; in_zero = 1'b0; in_op = '0; out_ready = 1'b0;
      m_zerr = 0; m_xfer = 0; m_pops = 0;

      //            rst iv z      zf op      ordy  ov z      cnt ir xf ze
      tbl[0]  = mk(1, 0, 8'h00, 0, OP_AND, 0,    0, 8'h00, 0, 1, 0, 0);
      tbl[1]  = mk(0, 1, 8'h05, 0, OP_ADD, 1,    1, 8'h05, 1, 1, 0, 0);
      tbl[2]  = mk(0, 0, 8'h00, 0, OP_AND, 1,    0, 8'h00, 0, 1, 1, 0);
      tbl[3]  = mk(0, 1, 8'h11, 0, OP_ADD, 0,    1, 8'h11, 1, 1, 1, 0);
      tbl[4]  = mk(0, 1, 8'h22, 0, OP_ADD, 0,    1, 8'h11, 2, 0, 1, 0);
      tbl[5]  = mk(0, 1, 8'h33, 1, OP_ADD, 0,    1, 8'h11, 2, 0, 1, 0);
      tbl[6]  = mk(0, 0, 8'h00, 0, OP_AND, 1,    1, 8'h22, 1, 1, 2, 0);
      tbl[7]  = mk(0, 0, 8'h00, 0, OP_AND, 1,    0, 8'h00, 0, 1, 3, 0);
      tbl[8]  = mk(0, 1, 8'h44, 0, OP_OR,  0,    1, 8'h44, 1, 1, 3, 0);
      tbl[9]  = mk(0, 1, 8'h55, 0, OP_OR,  0,    1, 8'h44, 2, 0, 3, 0);
      tbl[10] = mk(1, 0, 8'h00, 0, OP_AND, 0,    0, 8'h00, 0, 1, 0, 0);
      tbl[11] = mk(0, 1, 8'h00, 0, OP_AND, 1,    1, 8'h00, 1, 1, 0, 1);
      tbl[12] = mk(0, 1, 8'h07, 0, OP_OR,  1,    1, 8'h07, 1, 1, 1, 1);
      tbl[13] = mk(0, 0, 8'h00, 0, OP_AND, 1,    0, 8'h00, 0, 1, 2, 1);
      tbl[14] = mk(1, 0, 8'h00, 0, OP_AND, 0,    0, 8'h00, 0, 1, 0, 0);

      @(negedge clk);
      foreach (tbl[i]) begin
         reset = tbl[i].rst; in_valid = tbl[i].iv; in_z = tbl[i].z;
         in_zero = tbl[i].zf; in_op = tbl[i].op; out_ready = tbl[i].ordy;
         tick();
         chk($sformatf("tbl%0d.out_valid", i), int'(out_valid), int'(tbl[i].e_ov));
         chk($sformatf("tbl%0d.count", i), int'(count), int'(tbl[i].e_cnt));
         chk($sformatf("tbl%0d.in_ready", i), int'(in_ready), int'(tbl[i].e_ir));
         chk($sformatf("tbl%0d.xfer", i), int'(xfer_count), tbl[i].e_xf);
         chk($sformatf("tbl%0d.zero_err", i), int'(zero_err), int'(tbl[i].e_ze));
         if (tbl[i].e_ov) chk($sformatf("tbl%0d.out_z", i), int'(out_z), int'(tbl[i].e_z));
      end
      reset = 1'b0;

      // streaming subtract: one result per cycle, occupancy pinned at 1
      in_valid = 1'b1; out_ready = 1'b1; in_op = OP_SUB;
      for (int i = 0; i < 20; i++) begin
         a = $urandom_range(255); b = (i % 5 == 0) ? a : $urandom_range(255);
         d = 8'(a - b); in_z = d; in_zero = (d == 0);
         tick();
         chk("stream.count", int'(count), 1);
         chk("stream.z", int'(out_z), int'(d));
      end

      // transfer counter wrap: 16 pops bring a 4-bit counter back to its start
      start_x = m_xfer; m_pops = 0; budget = 0;
      while (m_pops < 16 && budget < 200) begin
         in_valid = $urandom_range(1); out_ready = 1'b1;
         in_z = 8'($urandom); in_zero = (in_z == 0); in_op = OP_ADD;
         tick();
         budget++;
      end
      chk("wrap.pops", m_pops, 16);
      chk("wrap.xfer", int'(xfer_count), start_x);

      // random mixed traffic with occasional bad zero flags and resets
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(99) == 0);
         in_valid = $urandom_range(1); out_ready = ($urandom_range(3) != 0);
         in_z = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
         in_zero = ($urandom_range(40) == 0) ? (in_z != 0) : (in_z == 0);
         in_op = 3'($urandom);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
